// File: rtl/drift_table_pkg.sv
// Shared defaults and state encodings for the drift table reader.
package drift_table_pkg;

    localparam int unsigned LOG_T_DEF  = 9;
    localparam int unsigned T_MAX_DEF  = 511;
    localparam int unsigned DATA_W_DEF = 18;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } fill_state_e;

    typedef enum logic {
        SWEEP_IDLE = 1'b0,
        SWEEP_RUN  = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/drift_table_ram.sv
// Simple dual-port table memory: one write port, one registered read port.
module drift_table_ram
    import drift_table_pkg::*;
#(
    parameter int unsigned ADDR_W = LOG_T_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/drift_table_reader.sv
// Drift table fill tracking plus random/sweep readout with 2-cycle read latency.
// Optional fill-integrity checker enabled by defining DRIFT_TABLE_CHECK_EN.
module drift_table_reader
    import drift_table_pkg::*;
#(
    parameter int unsigned T_MAX  = T_MAX_DEF,
    parameter int unsigned LOG_T  = LOG_T_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] iWrData,
    input  logic [LOG_T-1:0]  iWrAddr,
    input  logic              iWrValid,
    input  logic              iWrDone,
    input  logic              iClear,
    input  logic              iRdReq,
    input  logic [LOG_T-1:0]  iRdAddr,
    input  logic              iSweep,
    output logic [DATA_W-1:0] oRdData,
    output logic [LOG_T-1:0]  oRdAddr,
    output logic              oRdValid,
    output logic              oReady,
    output logic              oSweepDone,
    output logic              oFillErr
);

    fill_state_e       state_q, state_d;
    sweep_state_e      sweep_q, sweep_d;
    logic [LOG_T-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic              wr_en;
    logic              rd_en;
    logic              rd_last;
    logic [LOG_T-1:0]  rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              s1_valid;
    logic              s1_last;
    logic [LOG_T-1:0]  s1_addr;
    logic              out_last;

    // Fill FSM and read issue; iClear dominates every other request.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        sweep_cnt_d = sweep_cnt_q;
        rd_en       = 1'b0;
        rd_last     = 1'b0;
        rd_addr     = iRdAddr;
        wr_en       = iWrValid && (state_q != READY) && !iClear;

        case (state_q)
            EMPTY:   if (iClear) state_d = EMPTY; else if (iWrValid) state_d = FILL;
            FILL:    if (iClear) state_d = EMPTY; else if (iWrDone)  state_d = READY;
            READY:   if (iClear) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        case (sweep_q)
            SWEEP_IDLE: begin
                if (state_q == READY) begin
                    if (iRdReq) begin
                        rd_en   = 1'b1;
                        rd_addr = iRdAddr;
                    end
                    if (iSweep && !iClear) begin
                        sweep_d     = SWEEP_RUN;
                        sweep_cnt_d = '0;
                    end
                end
            end
            SWEEP_RUN: begin
                if (iClear) begin
                    sweep_d     = SWEEP_IDLE;
                    sweep_cnt_d = '0;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = sweep_cnt_q;
                    if (sweep_cnt_q == LOG_T'(T_MAX)) begin
                        rd_last     = 1'b1;
                        sweep_d     = SWEEP_IDLE;
                        sweep_cnt_d = '0;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + LOG_T'(1);
                    end
                end
            end
            default: begin
                sweep_d     = SWEEP_IDLE;
                sweep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= EMPTY;
            sweep_q     <= SWEEP_IDLE;
            sweep_cnt_q <= '0;
            oReady      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            sweep_cnt_q <= sweep_cnt_d;
            oReady      <= (state_d == READY);
        end
    end

    drift_table_ram #(
        .ADDR_W (LOG_T),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .wr_addr (iWrAddr),
        .wr_data (iWrData),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Read pipeline; a clear kills the pending sweep-done marker but lets data drain.
    always_ff @(posedge CLK or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_addr    <= '0;
            oRdValid   <= 1'b0;
            oRdData    <= '0;
            oRdAddr    <= '0;
            out_last   <= 1'b0;
            oSweepDone <= 1'b0;
        end else begin
            s1_valid   <= rd_en;
            s1_last    <= rd_last;
            s1_addr    <= rd_addr;
            oRdValid   <= s1_valid;
            out_last   <= s1_last && !iClear;
            oSweepDone <= out_last && !iClear;
            if (s1_valid) begin
                oRdData <= ram_rd_data;
                oRdAddr <= s1_addr;
            end
        end
    end

`ifdef DRIFT_TABLE_CHECK_EN
    localparam int unsigned CNT_W = LOG_T + 1;

    logic [CNT_W-1:0] fill_cnt_q;
    logic [CNT_W-1:0] fill_cnt_inc;
    logic             fill_err_q;

    // Saturating count of accepted writes since the table was last emptied.
    always_comb begin
        fill_cnt_inc = fill_cnt_q;
        if (wr_en && (fill_cnt_q != '1)) begin
            fill_cnt_inc = fill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge iRst_n) begin
        if (!iRst_n) begin
            fill_cnt_q <= '0;
            fill_err_q <= 1'b0;
        end else if (iClear) begin
            fill_cnt_q <= '0;
            fill_err_q <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_inc;
            if ((state_q == FILL && iWrDone && fill_cnt_inc != CNT_W'(T_MAX + 1)) ||
                (state_q == READY && iWrValid)) begin
                fill_err_q <= 1'b1;
            end
        end
    end

    assign oFillErr = fill_err_q;
`else
    assign oFillErr = 1'b0;
`endif

endmodule

// File: doc/drift_table_reader.md
DRIFT_TABLE_READER -- requirements
Module: drift_table_reader

Interface
REQ-001 SHALL have parameter T_MAX, default 511, meaning last table index.
REQ-002 SHALL have parameter LOG_T, default 9, meaning index width.
REQ-003 SHALL have parameter DATA_W, default 18, meaning entry width (3 integer, 15 fraction bits, S0*exp(t*mu) format).
REQ-004 SHALL have port CLK, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port iRst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port iWrData, input, DATA_W, meaning table entry from the drift generator.
REQ-007 SHALL have port iWrAddr, input, LOG_T, meaning entry index t.
REQ-008 SHALL have port iWrValid, input, 1, meaning iWrData/iWrAddr qualify this cycle.
REQ-009 SHALL have port iWrDone, input, 1, meaning a one-cycle pulse marking end of generation.
REQ-010 SHALL have port iClear, input, 1, meaning invalidate the table ahead of a new fill.
REQ-011 SHALL have port iRdReq, input, 1, meaning a random read request.
REQ-012 SHALL have port iRdAddr, input, LOG_T, meaning random read index.
REQ-013 SHALL have port iSweep, input, 1, meaning a pulse starting a sequential read of indices 0..T_MAX.
REQ-014 SHALL have port oRdData, output, DATA_W, meaning read entry.
REQ-015 SHALL have port oRdAddr, output, LOG_T, meaning the index belonging to oRdData.
REQ-016 SHALL have port oRdValid, output, 1, meaning oRdData/oRdAddr are valid.
REQ-017 SHALL have port oReady, output, 1, meaning the table is complete and readable.
REQ-018 SHALL have port oSweepDone, output, 1, meaning a one-cycle pulse after the last sweep entry.
REQ-019 SHALL have port oFillErr, output, 1, meaning a sticky fill-integrity error.

Function
REQ-020 SHALL implement the fill FSM EMPTY -> FILL on the first iWrValid, FILL -> READY on iWrDone, READY/FILL -> EMPTY on iClear.
REQ-021 SHALL write the memory at iWrAddr on every iWrValid while in EMPTY or FILL, and ignore writes while in READY.
REQ-022 SHALL ignore iWrDone while in EMPTY.
REQ-023 SHALL give iClear priority over a simultaneous iWrDone or iWrValid; the write is dropped and the state becomes EMPTY.
REQ-024 SHALL drive oReady high exactly when the state is READY.
REQ-025 SHALL accept iRdReq only when oReady is high, and return oRdData/oRdAddr with oRdValid exactly 2 cycles later.
REQ-026 SHALL drop iRdReq silently when oReady is low, with no oRdValid.
REQ-027 SHALL, on iSweep in READY while idle, issue one read per cycle for indices 0..T_MAX, giving T_MAX+1 consecutive oRdValid cycles.
REQ-028 SHALL pulse oSweepDone in the cycle after the last sweep oRdValid.
REQ-029 SHALL give an active sweep priority over iRdReq; iRdReq during a sweep is dropped.
REQ-030 SHALL ignore iSweep during an active sweep or outside READY.
REQ-031 SHALL, on iClear mid-sweep, abort the sweep: in-flight reads complete, no further reads are issued, and there is no oSweepDone.
REQ-032 SHALL wrap the sweep counter only through termination, never past T_MAX.

Reset
REQ-033 SHALL, on iRst_n low, immediately set state EMPTY, sweep idle, read pipeline flushed, oRdValid=0, oReady=0, oSweepDone=0, oFillErr=0, oRdData=0, oRdAddr=0.
REQ-034 SHALL leave memory contents unreset; a reset mid-operation requires a new fill.

Configuration
REQ-035 SHALL, with DRIFT_TABLE_CHECK_EN defined, count iWrValid writes accepted since EMPTY and set oFillErr on iWrDone with count != T_MAX+1, or on iWrValid in READY.
REQ-036 SHALL hold oFillErr cleared only by reset or iClear.
REQ-037 SHALL, without DRIFT_TABLE_CHECK_EN, tie oFillErr to 0 and omit the counter; all other behaviour is identical.

Structure
REQ-038 SHALL place LOG_T, T_MAX and DATA_W defaults and the fill-state enum (EMPTY, FILL, READY) in package drift_table_pkg.
REQ-039 SHALL instantiate sub-module drift_table_ram, a simple dual-port 2^LOG_T x DATA_W memory with one write port and one registered read port (1-cycle), plus one output register in the top level.

Verification
REQ-040 SHALL cover full fill: writes t=0..511 with data=t, then iWrDone -> oReady=1 next cycle; iRdReq addr 37 -> oRdValid 2 cycles later with data 37, addr 37.
REQ-041 SHALL cover read before ready: iRdReq addr 5 in FILL -> no oRdValid within 4 cycles.
REQ-042 SHALL cover sweep: iSweep in READY -> 512 consecutive oRdValid with oRdAddr 0..511, then oSweepDone for 1 cycle.
REQ-043 SHALL cover clear priority: iClear and iWrDone in the same cycle -> state EMPTY, oReady=0; iClear at sweep index 100 -> at most 2 further oRdValid and no oSweepDone.
REQ-044 SHALL cover the checker (macro defined): 511 writes then iWrDone -> oFillErr=1; iClear -> oFillErr=0.
REQ-045 SHALL cover async reset: iRst_n low mid-sweep -> oRdValid, oReady and oSweepDone low before the next CLK edge.
